// File: rtl/pit_timer.sv
// Programmable interval timer: a prescaler feeding a divider, producing a
// one-cycle registered tick per period and a sticky interrupt request that
// is cleared by an acknowledge strobe. Host writes load both the reload
// value and the live count of the addressed register.
module pit_timer #(
    parameter int unsigned PW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          wr_pre,
    input  logic          wr_div,
    input  logic [15:0]   din,
    input  logic          irq_ack,
    output logic [PW-1:0] pre_q,
    output logic [DW-1:0] div_q,
    output logic          tick,
    output logic          irq
);

    logic [PW-1:0] pre_rld_q, pre_rld_d;
    logic [DW-1:0] div_rld_q, div_rld_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick_q,    tick_d;
    logic          irq_q,     irq_d;

    logic          en;
    logic          pre_zero;
    logic          div_zero;
    logic          pre_evt;

    // Enable and prescale-event decode from the current register state
    always_comb begin
        en       = (pre_rld_q != '0);
        pre_zero = (pre_cnt_q == '0);
        div_zero = (div_cnt_q == '0);
        pre_evt  = en && pre_zero;
    end

    // Reload registers change only on host writes
    always_comb begin
        pre_rld_d = pre_rld_q;
        div_rld_d = div_rld_q;
        if (wr_pre) begin
            pre_rld_d = din[PW-1:0];
        end
        if (wr_div) begin
            div_rld_d = din[DW-1:0];
        end
    end

    // Prescaler: a write wins over counting; zero reloads instead of wrapping
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (wr_pre) begin
            pre_cnt_d = din[PW-1:0];
        end else if (en) begin
            if (pre_zero) begin
                pre_cnt_d = pre_rld_q;
            end else begin
                pre_cnt_d = pre_cnt_q - PW'(1);
            end
        end
    end

    // Divider: steps once per prescale event; a write wins over the step
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (wr_div) begin
            div_cnt_d = din[DW-1:0];
        end else if (pre_evt) begin
            if (div_zero) begin
                div_cnt_d = div_rld_q;
            end else begin
                div_cnt_d = div_cnt_q - DW'(1);
            end
        end
    end

    // Tick on the divider reload; a coincident divider write suppresses it
    always_comb begin
        tick_d = pre_evt && div_zero && !wr_div;
    end

    // Sticky interrupt: a pending tick takes precedence over acknowledge
    always_comb begin
        irq_d = irq_q;
        if (tick_q) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pre_rld_q <= '0;
            div_rld_q <= '0;
            pre_cnt_q <= '0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            pre_rld_q <= pre_rld_d;
            div_rld_q <= div_rld_d;
            pre_cnt_q <= pre_cnt_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            irq_q     <= irq_d;
        end
    end

    assign pre_q = pre_cnt_q;
    assign div_q = div_cnt_q;
    assign tick  = tick_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_pit_timer.sv
// Self-checking bench for pit_timer. Expected counts and ticks come from a
// closed-form model: with elapsed edges t since the prescaler was loaded,
// pre = p - t mod (p+1), div = d - (t div (p+1)) mod (d+1), and a tick
// follows every (p+1)*(d+1) edges.
module tb_pit_timer;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        wr_pre  = 1'b0;
    logic        wr_div  = 1'b0;
    logic [15:0] din     = '0;
    logic        irq_ack = 1'b0;
    logic [15:0] pre_q;
    logic [15:0] div_q;
    logic        tick;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    pit_timer #(.PW(16), .DW(16)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .wr_pre  (wr_pre),
        .wr_div  (wr_div),
        .din     (din),
        .irq_ack (irq_ack),
        .pre_q   (pre_q),
        .div_q   (div_q),
        .tick    (tick),
        .irq     (irq)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned exp_pre(int unsigned p, int unsigned t);
        return p - (t % (p + 1));
    endfunction

    function automatic int unsigned exp_div(int unsigned p, int unsigned d, int unsigned t);
        return d - ((t / (p + 1)) % (d + 1));
    endfunction

    function automatic logic exp_tick(int unsigned p, int unsigned d, int unsigned t);
        return (t != 0) && ((t % ((p + 1) * (d + 1))) == 0);
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset(int unsigned n);
        reset   = 1'b1;
        wr_pre  = 1'b0;
        wr_div  = 1'b0;
        irq_ack = 1'b0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic write_pre(input logic [15:0] v);
        wr_pre = 1'b1;
        din    = v;
        step();
        wr_pre = 1'b0;
    endtask

    task automatic write_div(input logic [15:0] v);
        wr_div = 1'b1;
        din    = v;
        step();
        wr_div = 1'b0;
    endtask

    task automatic write_both(input logic [15:0] v);
        wr_pre = 1'b1;
        wr_div = 1'b1;
        din    = v;
        step();
        wr_pre = 1'b0;
        wr_div = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        wr_pre  = 1'b1;
        wr_div  = 1'b1;
        din     = 16'($urandom_range(1, 16'hFFFF));
        irq_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({pre_q, div_q, tick, irq} !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got pre=%0d div=%0d tick=%b irq=%b, want all 0",
                         pre_q, div_q, tick, irq);
            end
        end
        reset  = 1'b0;
        wr_pre = 1'b0;
        wr_div = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_tests++;
            if (tick !== 1'b0 || pre_q !== 16'd0 || div_q !== 16'd0 || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got pre=%0d div=%0d tick=%b irq=%b, want 0 0 0 0",
                         i, pre_q, div_q, tick, irq);
            end
        end
    endtask

    task automatic test_basic_period();
        apply_reset(1);
        write_div(16'd3);
        write_pre(16'd2);
        for (int unsigned t = 0; t <= 40; t++) begin
            if (t > 0) step();
            n_tests++;
            if (pre_q !== 16'(exp_pre(2, t)) || div_q !== 16'(exp_div(2, 3, t)) ||
                tick !== exp_tick(2, 3, t) || irq !== (t > 12)) begin
                n_fail++;
                $display("FAIL basic t=%0d: got pre=%0d div=%0d tick=%b irq=%b, want %0d %0d %b %b",
                         t, pre_q, div_q, tick, irq, exp_pre(2, t), exp_div(2, 3, t),
                         exp_tick(2, 3, t), (t > 12));
            end
        end
    endtask

    task automatic test_random_periods();
        for (int it = 0; it < 8; it++) begin
            int unsigned p, d, last;
            logic        irq_m, ack_prev;
            apply_reset(1);
            if ($urandom_range(0, 1) == 1) begin
                p = $urandom_range(1, 6);
                d = p;
                write_both(16'(p));
            end else begin
                p = $urandom_range(1, 6);
                d = $urandom_range(0, 4);
                write_div(16'(d));
                write_pre(16'(p));
            end
            irq_m = 1'b0;
            last  = 3 * (p + 1) * (d + 1) + 3;
            for (int unsigned t = 0; t <= last; t++) begin
                if (t > 0) begin
                    irq_ack  = ($urandom_range(0, 3) == 0);
                    ack_prev = irq_ack;
                    step();
                    irq_ack = 1'b0;
                    if (exp_tick(p, d, t - 1)) irq_m = 1'b1;
                    else if (ack_prev)        irq_m = 1'b0;
                end
                n_tests++;
                if (pre_q !== 16'(exp_pre(p, t)) || div_q !== 16'(exp_div(p, d, t)) ||
                    tick !== exp_tick(p, d, t) || irq !== irq_m) begin
                    n_fail++;
                    $display("FAIL random p=%0d d=%0d t=%0d: got pre=%0d div=%0d tick=%b irq=%b, want %0d %0d %b %b",
                             p, d, t, pre_q, div_q, tick, irq, exp_pre(p, t), exp_div(p, d, t),
                             exp_tick(p, d, t), irq_m);
                end
            end
        end
    endtask

    task automatic test_disable();
        logic [15:0] div_hold;
        apply_reset(1);
        write_div(16'd1);
        write_pre(16'd2);
        repeat (4) step();
        write_pre(16'd0);
        div_hold = 16'(exp_div(2, 1, 5));
        n_tests++;
        if (pre_q !== 16'd0 || div_q !== div_hold || tick !== exp_tick(2, 1, 5)) begin
            n_fail++;
            $display("FAIL disable_write: got pre=%0d div=%0d tick=%b, want 0 %0d %b",
                     pre_q, div_q, tick, div_hold, exp_tick(2, 1, 5));
        end
        for (int i = 0; i < 50; i++) begin
            step();
            n_tests++;
            if (pre_q !== 16'd0 || div_q !== div_hold || tick !== 1'b0) begin
                n_fail++;
                $display("FAIL disable_freeze cyc %0d: got pre=%0d div=%0d tick=%b, want 0 %0d 0",
                         i, pre_q, div_q, tick, div_hold);
            end
        end
        write_div(16'd0);
        write_pre(16'd1);
        for (int unsigned t = 0; t <= 20; t++) begin
            if (t > 0) step();
            n_tests++;
            if (pre_q !== 16'(exp_pre(1, t)) || div_q !== 16'd0 || tick !== exp_tick(1, 0, t)) begin
                n_fail++;
                $display("FAIL min_period t=%0d: got pre=%0d div=%0d tick=%b, want %0d 0 %b",
                         t, pre_q, div_q, tick, exp_pre(1, t), exp_tick(1, 0, t));
            end
        end
    endtask

    task automatic test_collision();
        apply_reset(1);
        write_div(16'd1);
        write_pre(16'd2);
        repeat (5) step();
        // edge 6 is a prescale event with the divider at zero
        wr_div = 1'b1;
        din    = 16'd5;
        step();
        wr_div = 1'b0;
        n_tests++;
        if (tick !== 1'b0 || div_q !== 16'd5 || pre_q !== 16'd2) begin
            n_fail++;
            $display("FAIL collision_edge: got pre=%0d div=%0d tick=%b, want 2 5 0",
                     pre_q, div_q, tick);
        end
        for (int unsigned s = 1; s <= 20; s++) begin
            step();
            n_tests++;
            if (pre_q !== 16'(exp_pre(2, s)) || div_q !== 16'(exp_div(2, 5, s)) ||
                tick !== exp_tick(2, 5, s) || irq !== (s > 18)) begin
                n_fail++;
                $display("FAIL collision s=%0d: got pre=%0d div=%0d tick=%b irq=%b, want %0d %0d %b %b",
                         s, pre_q, div_q, tick, irq, exp_pre(2, s), exp_div(2, 5, s),
                         exp_tick(2, 5, s), (s > 18));
            end
        end
    endtask

    task automatic test_irq();
        int n;
        apply_reset(1);
        write_div(16'd0);
        write_pre(16'd3);
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        n_tests++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL irq_first_tick: got %0d cycles, want 4", n);
        end
        step();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set: got irq=%b, want 1", irq);
        end
        write_pre(16'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (irq !== 1'b1 || tick !== 1'b0) begin
                n_fail++;
                $display("FAIL irq_hold cyc %0d: got irq=%b tick=%b, want 1 0", i, irq, tick);
            end
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_ack_clear: got irq=%b, want 0", irq);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_ack_idle: got irq=%b, want 0", irq);
        end
        write_pre(16'd3);
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        n_tests++;
        if (n != 4 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_ack_vs_tick: got wait=%0d irq=%b, want 4 1", n, irq);
        end
        step();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_after_race: got irq=%b, want 1", irq);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        apply_reset(1);
        write_div(16'd1);
        write_pre(16'd4);
        repeat (2) step();
        n_tests++;
        if (div_q !== 16'(exp_div(4, 1, 2)) || div_q !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_pre: got div=%0d, want 1", div_q);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if ({pre_q, div_q, tick, irq} !== 34'd0) begin
            n_fail++;
            $display("FAIL midreset_zero: got pre=%0d div=%0d tick=%b irq=%b, want all 0",
                     pre_q, div_q, tick, irq);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (tick !== 1'b0 || pre_q !== 16'd0) begin
                n_fail++;
                $display("FAIL midreset_idle cyc %0d: got pre=%0d tick=%b, want 0 0", i, pre_q, tick);
            end
        end
        write_div(16'd1);
        write_pre(16'd4);
        n = 0;
        while (tick !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        n_tests++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL midreset_first_tick: got %0d cycles, want 10", n);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned a, b;
        apply_reset(1);
        a = $urandom_range(1, 5);
        b = $urandom_range(1, 5);
        write_both(16'(a));
        n_tests++;
        if (pre_q !== 16'(a) || div_q !== 16'(a)) begin
            n_fail++;
            $display("FAIL b2b_first: got pre=%0d div=%0d, want %0d %0d", pre_q, div_q, a, a);
        end
        write_both(16'(b));
        for (int unsigned t = 0; t <= 2 * (b + 1) * (b + 1) + 1; t++) begin
            if (t > 0) step();
            n_tests++;
            if (pre_q !== 16'(exp_pre(b, t)) || div_q !== 16'(exp_div(b, b, t)) ||
                tick !== exp_tick(b, b, t)) begin
                n_fail++;
                $display("FAIL b2b t=%0d: got pre=%0d div=%0d tick=%b, want %0d %0d %b",
                         t, pre_q, div_q, tick, exp_pre(b, t), exp_div(b, b, t), exp_tick(b, b, t));
            end
        end
        // a divider-only write leaves the prescaler counting undisturbed
        write_div(16'd7);
        n_tests++;
        if (pre_q !== 16'(exp_pre(b, 2 * (b + 1) * (b + 1) + 2)) || div_q !== 16'd7) begin
            n_fail++;
            $display("FAIL b2b_div_only: got pre=%0d div=%0d, want %0d 7",
                     pre_q, div_q, exp_pre(b, 2 * (b + 1) * (b + 1) + 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic_period();
        test_random_periods();
        test_disable();
        test_collision();
        test_irq();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pit_timer.md
Name: pit_timer

Overview:
- Programmable interval timer for Tom, built from a 16-bit prescaler and a 16-bit divider, both running on sys_clk.
- Produces a one-cycle tick. A sticky interrupt-request latch sits downstream of the tick and is cleared by an acknowledge strobe.
- Register writes from the host decoder load both the reload values and the live counts. The live counts can be read back.

Parameters:
- PW, 16, prescaler width in bits
- DW, 16, divider width in bits

Ports:
- sys_clk  in  1  system clock; the only clock; everything updates on its rising edge
- reset  in  1  synchronous reset, active-high
- wr_pre  in  1  write strobe for the prescaler
- wr_div  in  1  write strobe for the divider
- din  in  16  write data; low PW bits are used by the prescaler, low DW bits by the divider
- irq_ack  in  1  clears irq
- pre_q  out  PW  live prescaler count
- div_q  out  DW  live divider count
- tick  out  1  one-cycle pulse at the end of each period
- irq  out  1  sticky interrupt request

Behaviour:
- Clock and reset:
  - One clock, sys_clk.
  - reset is synchronous and active-high, sampled on the sys_clk rising edge.
  - While reset is high: pre_rld, div_rld, pre_cnt, div_cnt, tick and irq are all 0. reset overrides every other input.
  - Reset asserted mid-period discards the count. The timer stays disabled until the prescaler is written again.
- Enable:
  - en = (pre_rld != 0).
  - With en=0 both counts hold and tick stays 0. Writes are still accepted.
- Writes (registered, visible on pre_q/div_q the cycle after the strobe):
  - wr_pre: pre_rld <= din[PW-1:0] and pre_cnt <= din[PW-1:0].
  - wr_div: div_rld <= din[DW-1:0] and div_cnt <= din[DW-1:0].
  - A write to a register takes priority over counting of that register in the same cycle.
  - wr_pre and wr_div together load both from din.
  - A write to one register does not disturb the other register's count.
- Counting, each edge with en=1 and no write to the affected register:
  - If pre_cnt != 0: pre_cnt <= pre_cnt - 1.
  - If pre_cnt == 0 (prescale event): pre_cnt <= pre_rld, then:
    - if div_cnt != 0: div_cnt <= div_cnt - 1;
    - if div_cnt == 0: div_cnt <= div_rld and tick <= 1.
  - Otherwise tick <= 0.
  - If wr_div coincides with a prescale event, the divider takes the written value and no tick is generated. If only wr_pre coincides, the divider still steps.
- Period:
  - (pre_rld+1)*(div_rld+1) sys_clk cycles between ticks.
  - tick is registered and high for exactly one cycle.
  - div_rld=0 gives a tick every pre_rld+1 cycles.
  - pre_rld=1, div_rld=0 gives a tick every 2 cycles, the minimum period.
- Arithmetic:
  - Unsigned. Counts never decrement below 0; 0 always reloads, so there is no wrap to all-ones.
  - pre_rld=FFFF with div_rld=FFFF gives a period of 2^32 cycles.
- Interrupt latch:
  - irq <= 1 on the edge after tick=1.
  - irq <= 0 on the edge after irq_ack=1.
  - tick and irq_ack in the same cycle: set wins, irq stays 1.
  - irq_ack with irq=0 has no effect.
- Outputs: all registered; no combinational path from any input to any output.

Test Plan:
- Reset behaviour: reset high for 2 cycles with writes active -> pre_q=0, div_q=0, tick=0, irq=0. No tick for 100 cycles after release.
- Basic period: write div=3, then next cycle pre=2 -> tick high for exactly one cycle starting 12 edges after the pre write, then every 12 cycles. pre_q sequences 2,1,0,2; div_q sequences 3,2,1,0,3.
- Disable and re-enable:
  - Running with pre=2 → write pre=0 → counts freeze and tick stays 0 for 50 cycles.
  - Write pre=1 with div=0 → tick every 2 cycles.
- Write collision: wr_div=1 (din=5) on the exact cycle of a div_cnt==0 prescale event -> no tick that period, div_q=5 next cycle, and the next tick is 6 prescale events later.
- Interrupt latch:
  - tick → irq=1 and holds across 20 cycles with no ack.
  - irq_ack → irq=0 next cycle.
  - irq_ack coincident with tick → irq stays 1.
- Mid-period reset: reset pulse at div_q=1 with pre=4 -> all zero. After writing pre=4, div=1 again, the first tick comes exactly 10 cycles after the later write.
